// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared RV32I load/store encodings, FSM state type, size decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } lsu_state_t;

  // Access size in bytes; 0 marks an illegal funct3.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = 3'd1;
      F3_H, F3_HU: size_of = 3'd2;
      F3_W:        size_of = 3'd4;
      default:     size_of = 3'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_extend.sv
// ============================================================================
// Module   : lsu_load_extend
// Purpose  : Sign/zero extension of a right-justified load word by funct3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
      F3_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
      F3_BU:   data_o = {24'd0, data_i[7:0]};
      F3_HU:   data_o = {16'd0, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I load/store to word-aligned memory, splitting crossing accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit          SPLIT_EN = 1'b1,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  output logic        stall_o,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_en_o,
  output logic [3:0]  mem_byte_en_o,
  output logic [31:0] mem_wr_data_o,
  input  logic [31:0] mem_rd_data_i
);

  lsu_state_t  r_state;
  lsu_state_t  w_state_next;
  logic [31:0] r_capture;

  logic [2:0]  w_size;
  logic [1:0]  w_off;
  logic [3:0]  w_end;
  logic        w_legal;
  logic        w_cross;
  logic [3:0]  w_mask;
  logic [7:0]  w_be_wide;
  logic [63:0] w_wd_wide;
  logic [31:0] w_base;
  logic [31:0] w_first_rd;
  logic [31:0] w_second_rd;
  logic [31:0] w_ext_in;
  logic [31:0] w_ext_out;

  assign w_size  = size_of(funct3_i);
  assign w_off   = addr_i[1:0];
  assign w_end   = {2'b00, w_off} + {1'b0, w_size};
  assign w_legal = (w_size != 3'd0);
  assign w_cross = (w_end > 4'd4);
  assign w_base  = {addr_i[31:2], 2'b00};

  always_comb begin
    case (w_size)
      3'd1:    w_mask = 4'b0001;
      3'd2:    w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  // Low half of the wide vectors serves the first word, high half the next one.
  assign w_be_wide = {4'b0000, w_mask} << w_off;
  assign w_wd_wide = {32'd0, wr_data_i} << {w_off, 3'b000};

  assign w_first_rd  = mem_rd_data_i >> {w_off, 3'b000};
  assign w_second_rd = r_capture | (mem_rd_data_i << (6'd32 - {1'b0, w_off, 3'b000}));
  assign w_ext_in    = (r_state == SECOND) ? w_second_rd : w_first_rd;

  lsu_load_extend u_extend (
    .funct3_i (funct3_i),
    .data_i   (w_ext_in),
    .data_o   (w_ext_out)
  );

  always_comb begin
    w_state_next  = IDLE;
    stall_o       = 1'b0;
    rd_valid_o    = 1'b0;
    err_o         = 1'b0;
    rd_data_o     = 32'd0;
    mem_addr_o    = w_base;
    mem_wr_en_o   = 1'b0;
    mem_byte_en_o = 4'b0000;
    mem_wr_data_o = w_wd_wide[31:0];
    if (!rst && req_valid_i) begin
      if (r_state == SECOND) begin
        mem_addr_o    = w_base + 32'd4;
        mem_byte_en_o = w_be_wide[7:4];
        mem_wr_data_o = w_wd_wide[63:32];
        mem_wr_en_o   = req_we_i;
        rd_valid_o    = !req_we_i;
        rd_data_o     = req_we_i ? 32'd0 : w_ext_out;
      end else if (!w_legal || (w_cross && SPLIT_EN == 1'b0)) begin
        err_o      = 1'b1;
        rd_valid_o = !req_we_i;
        rd_data_o  = req_we_i ? 32'd0 : ERR_DATA;
      end else begin
        mem_byte_en_o = w_be_wide[3:0];
        mem_wr_en_o   = req_we_i;
        if (w_cross) begin
          stall_o      = 1'b1;
          w_state_next = SECOND;
        end else begin
          rd_valid_o = !req_we_i;
          rd_data_o  = req_we_i ? 32'd0 : w_ext_out;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_capture <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_state_next == SECOND)
        r_capture <= w_first_rd;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit against a byte-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wr_data;

  logic        stall, rd_valid, err, mem_wen;
  logic [31:0] rd_data, mem_addr, mem_wd, mem_rd;
  logic [3:0]  mem_be;

  logic        n_stall, n_rd_valid, n_err, n_mem_wen;
  logic [31:0] n_rd_data, n_mem_addr, n_mem_wd, n_mem_rd;
  logic [3:0]  n_mem_be;

  always #5 clk = ~clk;

  load_store_unit #(.SPLIT_EN(1'b1), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_we_i(req_we), .funct3_i(funct3),
    .addr_i(addr), .wr_data_i(wr_data), .stall_o(stall), .rd_data_o(rd_data),
    .rd_valid_o(rd_valid), .err_o(err), .mem_addr_o(mem_addr), .mem_wr_en_o(mem_wen),
    .mem_byte_en_o(mem_be), .mem_wr_data_o(mem_wd), .mem_rd_data_i(mem_rd)
  );

  load_store_unit #(.SPLIT_EN(1'b0), .ERR_DATA(32'hDEADBEEF)) dut_n (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_we_i(req_we), .funct3_i(funct3),
    .addr_i(addr), .wr_data_i(wr_data), .stall_o(n_stall), .rd_data_o(n_rd_data),
    .rd_valid_o(n_rd_valid), .err_o(n_err), .mem_addr_o(n_mem_addr), .mem_wr_en_o(n_mem_wen),
    .mem_byte_en_o(n_mem_be), .mem_wr_data_o(n_mem_wd), .mem_rd_data_i(n_mem_rd)
  );

  // 256-byte memory, aliased over the full address space by the low 8 address bits.
  logic [31:0] mem [64];
  logic [7:0]  ref_mem [256];
  logic        set_req = 1'b0;
  logic [5:0]  set_idx;
  logic [31:0] set_val;

  assign mem_rd   = mem[mem_addr[7:2]];
  assign n_mem_rd = mem[n_mem_addr[7:2]];

  always @(posedge clk) begin
    if (set_req) mem[set_idx] <= set_val;
    else if (mem_wen)
      for (int k = 0; k < 4; k++)
        if (mem_be[k]) mem[mem_addr[7:2]][8*k +: 8] <= mem_wd[8*k +: 8];
  end

  int total = 0;
  int bad   = 0;

  logic [31:0] o_addr [2];
  logic [31:0] o_wd   [2];
  logic [3:0]  o_be   [2];
  logic        o_stall[2];
  logic        o_wen  [2];
  logic [31:0] o_rd, x_rd;
  logic        o_rv, o_err;
  int          o_cyc;
  logic        x_err, x_stall, x_rv, x_wen;
  logic [3:0]  x_be;

  function automatic int ref_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = ref_mem[a[7:0] + 8'(k)];
    case (f3)
      F3_B:    return {{24{b[0][7]}}, b[0]};
      F3_H:    return {{16{b[1][7]}}, b[1], b[0]};
      F3_BU:   return {24'd0, b[0]};
      F3_HU:   return {16'd0, b[1], b[0]};
      default: return {b[3], b[2], b[1], b[0]};
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    for (int k = 0; k < ref_size(f3); k++) ref_mem[a[7:0] + 8'(k)] = wd[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_word(input logic [5:0] idx);
    return {ref_mem[{idx, 2'd3}], ref_mem[{idx, 2'd2}], ref_mem[{idx, 2'd1}], ref_mem[{idx, 2'd0}]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    set_idx = a[7:2]; set_val = v; set_req = 1'b1;
    @(posedge clk); #1 set_req = 1'b0;
    for (int k = 0; k < 4; k++) ref_mem[{a[7:2], 2'(k)}] = v[8*k +: 8];
  endtask

  // Drives one request from posedge+1 until the cycle without stall (max 3 cycles).
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    logic st;
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wr_data = wd;
    o_cyc = 0; o_rv = 1'b0; o_err = 1'b0; o_rd = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c < 2) begin
        o_addr[c] = mem_addr; o_wd[c] = mem_wd; o_be[c] = mem_be;
        o_stall[c] = stall; o_wen[c] = mem_wen;
      end
      if (c == 0) begin x_err = n_err; x_rd = n_rd_data; x_stall = n_stall; x_rv = n_rd_valid; end
      o_cyc = c + 1;
      if (rd_valid) begin o_rv = 1'b1; o_rd = rd_data; end
      if (err) o_err = 1'b1;
      st = stall;
      @(posedge clk); #1;
      if (!st) break;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; funct3 = F3_W; addr = 32'h102; wr_data = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    total++; if (mem_wen !== 1'b0 || mem_be !== 4'b0) begin bad++; $display("FAIL reset_wen_be: got %b/%b want 0/0000", mem_wen, mem_be); end
    req_we = 1'b0;
    #1;
    total++; if (rd_valid !== 1'b0 || err !== 1'b0 || rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd: got rv=%b err=%b rd=%h want 0 0 0", rd_valid, err, rd_data); end
    @(posedge clk); #1 rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    total++; if (stall !== 1'b0 || mem_be !== 4'b0 || rd_valid !== 1'b0 || mem_addr !== 32'h100) begin bad++; $display("FAIL idle_outputs: got st=%b be=%b rv=%b addr=%h want 0 0000 0 100", stall, mem_be, rd_valid, mem_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_aligned();
    access(1'b1, F3_W, 32'h100, 32'h11223344); ref_store(32'h100, F3_W, 32'h11223344);
    total++; if (o_cyc !== 1 || o_stall[0] !== 1'b0) begin bad++; $display("FAIL sw_cycles: got %0d st=%b want 1 0", o_cyc, o_stall[0]); end
    total++; if (o_addr[0] !== 32'h100 || o_be[0] !== 4'b1111 || o_wen[0] !== 1'b1) begin bad++; $display("FAIL sw_addr_be: got %h %b %b want 100 1111 1", o_addr[0], o_be[0], o_wen[0]); end
    total++; if (o_wd[0] !== 32'h11223344) begin bad++; $display("FAIL sw_data: got %h want 11223344", o_wd[0]); end
    access(1'b1, F3_B, 32'h103, 32'h000000AB); ref_store(32'h103, F3_B, 32'hAB);
    total++; if (o_be[0] !== 4'b1000 || o_wd[0] !== 32'hAB000000) begin bad++; $display("FAIL sb_lane: got %b %h want 1000 ab000000", o_be[0], o_wd[0]); end
    total++; if (mem[0] !== 32'hAB223344) begin bad++; $display("FAIL sb_mem: got %h want ab223344", mem[0]); end
    set_word(32'h100, 32'h80FF0000);
    access(1'b0, F3_B, 32'h103, 32'h0);
    total++; if (o_rv !== 1'b1 || o_rd !== 32'hFFFFFF80 || o_cyc !== 1) begin bad++; $display("FAIL lb: got rv=%b %h cyc=%0d want 1 ffffff80 1", o_rv, o_rd, o_cyc); end
    access(1'b0, F3_BU, 32'h103, 32'h0);
    total++; if (o_rd !== 32'h00000080) begin bad++; $display("FAIL lbu: got %h want 00000080", o_rd); end
    access(1'b0, F3_HU, 32'h102, 32'h0);
    total++; if (o_rd !== 32'h000080FF) begin bad++; $display("FAIL lhu: got %h want 000080ff", o_rd); end
  endtask

  task automatic test_crossing();
    access(1'b1, F3_W, 32'h102, 32'h11223344); ref_store(32'h102, F3_W, 32'h11223344);
    total++; if (o_cyc !== 2 || o_stall[0] !== 1'b1 || o_stall[1] !== 1'b0) begin bad++; $display("FAIL xsw_stall: got cyc=%0d %b%b want 2 10", o_cyc, o_stall[0], o_stall[1]); end
    total++; if (o_addr[0] !== 32'h100 || o_be[0] !== 4'b1100 || o_wd[0] !== 32'h33440000) begin bad++; $display("FAIL xsw_first: got %h %b %h want 100 1100 33440000", o_addr[0], o_be[0], o_wd[0]); end
    total++; if (o_addr[1] !== 32'h104 || o_be[1] !== 4'b0011 || o_wd[1] !== 32'h00001122) begin bad++; $display("FAIL xsw_second: got %h %b %h want 104 0011 00001122", o_addr[1], o_be[1], o_wd[1]); end
    set_word(32'h100, 32'hAB000000);
    set_word(32'h104, 32'h000000CD);
    access(1'b0, F3_H, 32'h103, 32'h0);
    total++; if (o_cyc !== 2 || o_rv !== 1'b1 || o_rd !== 32'hFFFFCDAB) begin bad++; $display("FAIL xlh: got cyc=%0d rv=%b %h want 2 1 ffffcdab", o_cyc, o_rv, o_rd); end
    access(1'b0, F3_HU, 32'h103, 32'h0);
    total++; if (o_rd !== 32'h0000CDAB) begin bad++; $display("FAIL xlhu: got %h want 0000cdab", o_rd); end
    set_word(32'hFFFFFFFC, 32'h44332211);
    set_word(32'h00000000, 32'h88776655);
    access(1'b0, F3_W, 32'hFFFFFFFE, 32'h0);
    total++; if (o_addr[0] !== 32'hFFFFFFFC || o_addr[1] !== 32'h00000000) begin bad++; $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", o_addr[0], o_addr[1]); end
    total++; if (o_rd !== 32'h66554433) begin bad++; $display("FAIL wrap_data: got %h want 66554433", o_rd); end
    total++; if (x_err !== 1'b1 || x_rd !== 32'hDEADBEEF || x_stall !== 1'b0 || x_rv !== 1'b1) begin bad++; $display("FAIL nosplit: got err=%b %h st=%b rv=%b want 1 deadbeef 0 1", x_err, x_rd, x_stall, x_rv); end
    access(1'b0, F3_W, 32'h000000A4, 32'h0);
    total++; if (x_err !== 1'b0 || x_rd !== ref_load(32'hA4, F3_W)) begin bad++; $display("FAIL nosplit_ok: got err=%b %h want 0 %h", x_err, x_rd, ref_load(32'hA4, F3_W)); end
  endtask

  task automatic test_illegal();
    logic [2:0] f3s [3];
    f3s[0] = 3'b011; f3s[1] = 3'b110; f3s[2] = 3'b111;
    for (int i = 0; i < 3; i++) begin
      access(1'b0, f3s[i], 32'h40 + 32'(i), 32'h0);
      total++; if (o_err !== 1'b1 || o_rd !== 32'hDEADBEEF || o_rv !== 1'b1) begin bad++; $display("FAIL illegal_ld: got err=%b %h rv=%b want 1 deadbeef 1", o_err, o_rd, o_rv); end
      total++; if (o_be[0] !== 4'b0 || o_cyc !== 1) begin bad++; $display("FAIL illegal_be: got %b cyc=%0d want 0000 1", o_be[0], o_cyc); end
      access(1'b1, f3s[i], 32'h42, 32'hFFFFFFFF);
      total++; if (o_wen[0] !== 1'b0 || o_err !== 1'b1) begin bad++; $display("FAIL illegal_st: got wen=%b err=%b want 0 1", o_wen[0], o_err); end
    end
  endtask

  task automatic test_abort();
    set_word(32'h10, 32'h0); set_word(32'h14, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; funct3 = F3_W; addr = 32'h11; wr_data = 32'hA1B2C3D4;
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL abort_stall: got %b want 1", stall); end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    x_wen = mem_wen; x_be = mem_be;
    total++; if (x_wen !== 1'b0 || x_be !== 4'b0 || stall !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL abort_out: got wen=%b be=%b st=%b rv=%b want 0 0000 0 0", x_wen, x_be, stall, rd_valid); end
    @(posedge clk); #1;
    ref_mem[8'h11] = 8'hD4; ref_mem[8'h12] = 8'hC3; ref_mem[8'h13] = 8'hB2;
    total++; if (mem[4] !== ref_word(6'd4) || mem[5] !== 32'h0) begin bad++; $display("FAIL abort_mem: got %h %h want %h 00000000", mem[4], mem[5], ref_word(6'd4)); end
    access(1'b0, F3_H, 32'h12, 32'h0);
    total++; if (o_cyc !== 1 || o_rd !== 32'hFFFFB2C3) begin bad++; $display("FAIL abort_next: got cyc=%0d %h want 1 ffffb2c3", o_cyc, o_rd); end
  endtask

  task automatic test_reset_second();
    set_word(32'h100, 32'h0); set_word(32'h104, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; funct3 = F3_W; addr = 32'h102; wr_data = 32'hAABBCCDD;
    @(posedge clk); #1;
    total++; if (mem_be !== 4'b0011) begin bad++; $display("FAIL rs_second: got %b want 0011", mem_be); end
    rst = 1'b1; #1;
    total++; if (stall !== 1'b0 || mem_wen !== 1'b0 || mem_be !== 4'b0) begin bad++; $display("FAIL rs_out: got st=%b wen=%b be=%b want 0 0 0000", stall, mem_wen, mem_be); end
    @(posedge clk); #1 rst = 1'b0; req_valid = 1'b0;
    ref_mem[8'h02] = 8'hDD; ref_mem[8'h03] = 8'hCC;
    total++; if (mem[0] !== 32'hCCDD0000 || mem[1] !== 32'h0) begin bad++; $display("FAIL rs_mem: got %h %h want ccdd0000 00000000", mem[0], mem[1]); end
    access(1'b0, F3_W, 32'h100, 32'h0);
    total++; if (o_cyc !== 1 || o_stall[0] !== 1'b0 || o_rd !== 32'hCCDD0000) begin bad++; $display("FAIL rs_idle: got cyc=%0d st=%b %h want 1 0 ccdd0000", o_cyc, o_stall[0], o_rd); end
  endtask

  task automatic test_random();
    logic [2:0]  f3s [5];
    logic [2:0]  f3;
    logic [31:0] a, wd, exp;
    logic        we;
    int          exp_cyc;
    f3s[0] = F3_B; f3s[1] = F3_H; f3s[2] = F3_W; f3s[3] = F3_BU; f3s[4] = F3_HU;
    for (int i = 0; i < 300; i++) begin
      f3 = f3s[$urandom_range(0, 4)];
      we = f3[2] ? 1'b0 : 1'($urandom_range(0, 1));
      a  = $urandom; wd = $urandom;
      exp_cyc = (int'(a[1:0]) + ref_size(f3) > 4) ? 2 : 1;
      exp = ref_load(a, f3);
      access(we, f3, a, wd);
      total++; if (o_cyc !== exp_cyc || o_err !== 1'b0) begin bad++; $display("FAIL rnd_cyc: a=%h f3=%b got cyc=%0d err=%b want %0d 0", a, f3, o_cyc, o_err, exp_cyc); end
      if (we) ref_store(a, f3, wd);
      else begin
        total++; if (o_rv !== 1'b1 || o_rd !== exp) begin bad++; $display("FAIL rnd_load: a=%h f3=%b got rv=%b %h want 1 %h", a, f3, o_rv, o_rd, exp); end
      end
    end
    for (int i = 0; i < 64; i++) begin
      total++; if (mem[i] !== ref_word(6'(i))) begin bad++; $display("FAIL rnd_mem[%0d]: got %h want %h", i, mem[i], ref_word(6'(i))); end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; funct3 = F3_W; addr = 32'h0; wr_data = 32'h0;
    set_idx = 6'd0; set_val = 32'h0;
    test_reset();
    for (int i = 0; i < 64; i++) set_word(32'(i * 4), $urandom);
    test_aligned();
    test_crossing();
    test_illegal();
    test_abort();
    test_reset_second();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute/memory pipeline stage and the byte-addressed data memory.
- Converts a RV32I load/store request (funct3, byte address, store data) into word-aligned memory accesses with byte enables, lane-shifted write data, and sign/zero-extended load results.
- Accesses that cross a word boundary are split into two back-to-back aligned accesses, with a pipeline stall for one cycle.

Parameters:
- SPLIT_EN, 1, 1 = split word-crossing accesses into two accesses; 0 = flag them as errors.
- ERR_DATA, 32'hDEADBEEF, load result returned on any error.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid_i  in  1  load/store request present; held stable by the pipeline while stall_o=1
- req_we_i  in  1  1 = store, 0 = load
- funct3_i  in  3  RV32I width/sign code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- addr_i  in  32  byte address
- wr_data_i  in  32  store data, right-justified
- stall_o  out  1  hold the pipeline this cycle
- rd_data_o  out  32  extended load result
- rd_valid_o  out  1  rd_data_o is final this cycle
- err_o  out  1  illegal funct3, or crossing access with SPLIT_EN=0
- mem_addr_o  out  32  word-aligned address, bits [1:0] always 00
- mem_wr_en_o  out  1  memory write strobe
- mem_byte_en_o  out  4  byte lane enables
- mem_wr_data_o  out  32  lane-shifted store data
- mem_rd_data_i  in  32  combinational memory read word

Behaviour:
- Lane convention: byte at address A+k occupies word bits [8k+7:8k], for both reads and writes.
- Definitions: size = 1/2/4 bytes from funct3; off = addr_i[1:0]; crossing = (off + size > 4).
- Illegal funct3 (011, 110, 111), with req_valid_i=1:
  - err_o=1, rd_data_o=ERR_DATA, rd_valid_o=1 for loads.
  - mem_wr_en_o=0, mem_byte_en_o=0; FSM stays in IDLE.
- FSM states: IDLE, SECOND.
- IDLE, non-crossing access (zero latency, all combinational):
  - mem_addr_o = addr_i & ~3.
  - mem_byte_en_o = size mask << off.
  - mem_wr_data_o = wr_data_i << 8*off.
  - mem_wr_en_o = req_we_i.
  - Loads: rd_data_o is extracted from mem_rd_data_i and extended in the same cycle; rd_valid_o=1; stall_o=0.
- IDLE, crossing access, SPLIT_EN=1:
  - First half: mem_addr_o = addr_i & ~3, mem_byte_en_o = lanes off..3, write data shifted by 8*off.
  - stall_o=1, rd_valid_o=0.
  - On the clock edge, lanes off..3 of mem_rd_data_i are captured into the low bytes of the capture register; go to SECOND.
- SECOND:
  - mem_addr_o = (addr_i & ~3) + 4, wrapping modulo 2^32.
  - mem_byte_en_o = lanes 0..(off + size - 5).
  - mem_wr_data_o = wr_data_i >> 8*(4 - off).
  - Loads: rd_data_o = extend({upper bytes from mem_rd_data_i, captured bytes}); rd_valid_o=1.
  - stall_o=0; next state IDLE.
- Crossing access with SPLIT_EN=0:
  - err_o=1, no write, rd_data_o=ERR_DATA, rd_valid_o=1 for loads, stall_o=0.
- req_valid_i deasserted while in SECOND: abort, no second access, return to IDLE, rd_valid_o=0.
- Extension rules:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- req_valid_i=0: all memory strobes 0, rd_valid_o=0, err_o=0, stall_o=0; mem_addr_o still reflects addr_i & ~3.
- While rst=1: state=IDLE, capture register=0, mem_wr_en_o=0, mem_byte_en_o=0, stall_o=0, rd_valid_o=0, err_o=0, rd_data_o=0.
- Reset during SECOND: abort immediately. The first-half write is already committed; crossing stores are not atomic.

Decomposition:
- Package lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU); state enum lsu_state_t {IDLE, SECOND}; function size_of(funct3).
- Sub-module lsu_load_extend: combinational. Takes the assembled 32-bit byte-shifted data plus funct3 and returns the extended result. Shared by the single-cycle and split paths.

Test Plan:
- SW 0x11223344 @0x100 -> one cycle: mem_addr 0x100, byte_en 1111, wr_data 0x11223344, stall 0.
- SB 0x000000AB @0x103 -> byte_en 1000, wr_data 0xAB000000; memory word 0x80FF0000, then LB @0x103 -> 0xFFFFFF80, LBU -> 0x00000080.
- SW 0x11223344 @0x102 (crossing) -> cycle 1: addr 0x100, byte_en 1100, wr_data 0x33440000, stall 1; cycle 2: addr 0x104, byte_en 0011, wr_data 0x00001122, stall 0.
- LH @0x103 with word 0x100 lane3=0xAB and word 0x104 lane0=0xCD -> cycle 2: rd_data 0xFFFFCDAB, rd_valid 1; LHU -> 0x0000CDAB.
- LW @0xFFFFFFFE -> second access addr 0x00000000 (wrap). With SPLIT_EN=0: err_o 1, rd_data 0xDEADBEEF, no stall.
- funct3=011 load -> err_o 1, byte_en 0000. Assert rst in SECOND of a crossing SW -> only the first-half lanes are written; FSM returns to IDLE, stall_o 0.
